// File: rtl/key_matrix_scanner.sv
// 4x8 key matrix scanner: drives one column low at a time, debounces all 32 keys
// and reports press/release events one at a time over a valid/ready handshake.
module key_matrix_scanner #(
    parameter int unsigned SETTLE_BITS    = 16,
    parameter int unsigned DEBOUNCE_COUNT = 3
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [7:0]  i_row_sense,
    output logic [3:0]  o_column_enable,
    output logic [31:0] o_keys,
    output logic        o_event_valid,
    output logic [4:0]  o_event_key,
    output logic        o_event_pressed,
    input  logic        i_event_ready
);

    typedef enum logic [1:0] {SETTLE, SAMPLE, EMIT, NEXT} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SETTLE_BITS-1:0] timer;
    logic [1:0]             col;
    logic [2:0]             row;
    logic [7:0]             row_meta;
    logic [7:0]             row_sync;
    logic [7:0]             sample;
    logic [7:0]             changed;
    logic [31:0]            keys;
    logic [31:0][1:0]       count;
    logic                   advance;

    // Synchronizer idles at the pulled-up level so reset never looks like a closed key
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= i_row_sense;
            row_sync <= row_meta;
        end
    end

    assign sample = ~row_sync;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= SETTLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SETTLE: if (timer == '1) state_next = SAMPLE;
            SAMPLE: state_next = EMIT;
            EMIT:   if (advance && (row == 3'd7)) state_next = NEXT;
            NEXT:   state_next = SETTLE;
            default: state_next = SETTLE;
        endcase
    end

    always_comb begin
        o_event_valid   = (state == EMIT) && changed[row];
        o_event_key     = {col, row};
        o_event_pressed = keys[{col, row}];
        o_column_enable = ~(4'b0001 << col);
        o_keys          = keys;
        // A row is finished once it has nothing to report or its event is taken
        advance         = (state == EMIT) && (!changed[row] || i_event_ready);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            timer   <= '0;
            col     <= '0;
            row     <= '0;
            changed <= '0;
            keys    <= '0;
            count   <= '0;
        end else begin
            case (state)
                SETTLE: timer <= timer + SETTLE_BITS'(1);
                SAMPLE: begin
                    row <= '0;
                    for (int unsigned r = 0; r < 8; r++) begin
                        if (sample[r] == keys[{col, 3'(r)}]) begin
                            count[{col, 3'(r)}] <= '0;
                            changed[r]          <= 1'b0;
                        end else if (({1'b0, count[{col, 3'(r)}]} + 3'd1) == 3'(DEBOUNCE_COUNT)) begin
                            keys[{col, 3'(r)}]  <= ~keys[{col, 3'(r)}];
                            count[{col, 3'(r)}] <= '0;
                            changed[r]          <= 1'b1;
                        end else begin
                            count[{col, 3'(r)}] <= count[{col, 3'(r)}] + 2'd1;
                            changed[r]          <= 1'b0;
                        end
                    end
                end
                EMIT: begin
                    if (advance) begin
                        changed[row] <= 1'b0;
                        row          <= row + 3'd1;
                    end
                end
                NEXT: begin
                    col   <= col + 2'd1;
                    timer <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner with SETTLE_BITS=2 (14-clock column period);
// a physical key matrix model drives the row lines from the column enables.
module tb_key_matrix_scanner;

    typedef struct packed {
        logic [31:0] cyc;
        logic [4:0]  key;
        logic        pressed;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  row_sense;
    logic [31:0] pressed;
    logic [3:0]  col_en;
    logic [31:0] keys;
    logic        ev_valid;
    logic [4:0]  ev_key;
    logic        ev_pressed;
    logic        ready;
    logic [3:0]  col_en1;
    logic [31:0] keys1;
    logic        ev_valid1;
    logic [4:0]  ev_key1;
    logic        ev_pressed1;
    logic        ready1;

    int  cyc;
    int  n_checks;
    int  n_fail;
    ev_t q[$];
    ev_t q1[$];

    key_matrix_scanner #(.SETTLE_BITS(2), .DEBOUNCE_COUNT(2)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_row_sense(row_sense),
        .o_column_enable(col_en), .o_keys(keys), .o_event_valid(ev_valid),
        .o_event_key(ev_key), .o_event_pressed(ev_pressed), .i_event_ready(ready)
    );

    key_matrix_scanner #(.SETTLE_BITS(2), .DEBOUNCE_COUNT(1)) dut1 (
        .i_clock(clk), .i_reset_n(rst_n), .i_row_sense(row_sense),
        .o_column_enable(col_en1), .o_keys(keys1), .o_event_valid(ev_valid1),
        .o_event_key(ev_key1), .o_event_pressed(ev_pressed1), .i_event_ready(ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Closed key pulls its row low only while its column is driven
    always_comb begin
        row_sense = '1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 8; r++)
                if (!col_en[c] && pressed[c*8+r]) row_sense[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst_n) cyc = 0;
        else        cyc = cyc + 1;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            q1.delete();
        end else begin
            if (ev_valid && ready)   q.push_back('{cyc: cyc, key: ev_key, pressed: ev_pressed});
            if (ev_valid1 && ready1) q1.push_back('{cyc: cyc, key: ev_key1, pressed: ev_pressed1});
        end
    end

    task automatic apply_reset(input logic [31:0] init_keys, input logic init_ready);
        @(negedge clk); #1;
        rst_n   = 1'b0;
        pressed = init_keys;
        ready   = init_ready;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        rst_n = 1'b0; pressed = '0; ready = 1'b1;
        #2;
        n_checks++; if (col_en !== 4'b1110) begin n_fail++; $display("FAIL reset_col got %b want 1110", col_en); end
        n_checks++; if (keys !== 32'h0) begin n_fail++; $display("FAIL reset_keys got %h want 0", keys); end
        n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ev_valid); end
        n_checks++; if (ev_key !== 5'd0) begin n_fail++; $display("FAIL reset_key got %0d want 0", ev_key); end
        n_checks++; if (ev_pressed !== 1'b0) begin n_fail++; $display("FAIL reset_pressed got %b want 0", ev_pressed); end
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_col;
        apply_reset(32'h0, 1'b1);
        for (int i = 1; i <= 57; i++) begin
            wait_until(i);
            exp_col = ~(4'b0001 << (((i - 1) / 14) % 4));
            n_checks++; if (col_en !== exp_col) begin n_fail++; $display("FAIL idle_col cyc %0d got %b want %b", i, col_en, exp_col); end
            n_checks++; if (keys !== 32'h0) begin n_fail++; $display("FAIL idle_keys cyc %0d got %h want 0", i, keys); end
            n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid cyc %0d got %b want 0", i, ev_valid); end
        end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL idle_events got %0d want 0", q.size()); end
    endtask

    task automatic test_press_release();
        apply_reset(32'h0008_0000, 1'b1);
        wait_until(60);
        n_checks++; if (keys !== 32'h0) begin n_fail++; $display("FAIL pr_first_sample keys got %h want 0", keys); end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL pr_first_sample events got %0d want 0", q.size()); end
        wait_until(92);
        n_checks++; if (keys !== 32'h0008_0000) begin n_fail++; $display("FAIL pr_press keys got %h want 00080000", keys); end
        wait_until(93);
        n_checks++; if (ev_valid !== 1'b1 || ev_key !== 5'd19 || ev_pressed !== 1'b1) begin
            n_fail++; $display("FAIL pr_event valid/key/pressed got %b/%0d/%b want 1/19/1", ev_valid, ev_key, ev_pressed);
        end
        wait_until(100);
        n_checks++;
        if (q.size() != 1) begin n_fail++; $display("FAIL pr_press_count got %0d want 1", q.size()); end
        else begin
            n_checks++; if (q[0] !== ev_t'{cyc: 93, key: 5'd19, pressed: 1'b1}) begin
                n_fail++; $display("FAIL pr_press_event got cyc %0d key %0d p %b want 93/19/1", q[0].cyc, q[0].key, q[0].pressed);
            end
        end
        pressed = '0;
        wait_until(150);
        n_checks++; if (keys !== 32'h0008_0000) begin n_fail++; $display("FAIL pr_release_early keys got %h want 00080000", keys); end
        wait_until(210);
        n_checks++; if (keys !== 32'h0) begin n_fail++; $display("FAIL pr_release keys got %h want 0", keys); end
        n_checks++;
        if (q.size() != 2) begin n_fail++; $display("FAIL pr_release_count got %0d want 2", q.size()); end
        else begin
            n_checks++; if (q[1] !== ev_t'{cyc: 205, key: 5'd19, pressed: 1'b0}) begin
                n_fail++; $display("FAIL pr_release_event got cyc %0d key %0d p %b want 205/19/0", q[1].cyc, q[1].key, q[1].pressed);
            end
        end
    endtask

    task automatic test_glitch();
        apply_reset(32'h0, 1'b1);
        wait_until(15);  pressed[13] = 1'b1;
        wait_until(22);  pressed = '0;
        wait_until(60);
        n_checks++; if (keys !== 32'h0) begin n_fail++; $display("FAIL glitch_keys1 got %h want 0", keys); end
        wait_until(127); pressed[13] = 1'b1;
        wait_until(134); pressed = '0;
        wait_until(190);
        n_checks++; if (keys !== 32'h0) begin n_fail++; $display("FAIL glitch_keys2 got %h want 0", keys); end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL glitch_events got %0d want 0", q.size()); end
    endtask

    task automatic test_back_to_back();
        apply_reset(32'h0018_0000, 1'b1);
        wait_until(93);
        n_checks++; if (ev_valid !== 1'b1 || ev_key !== 5'd19) begin n_fail++; $display("FAIL b2b_first got %b/%0d want 1/19", ev_valid, ev_key); end
        wait_until(94);
        n_checks++; if (ev_valid !== 1'b1 || ev_key !== 5'd20) begin n_fail++; $display("FAIL b2b_second got %b/%0d want 1/20", ev_valid, ev_key); end
        wait_until(96);
        n_checks++;
        if (q.size() != 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", q.size()); end
        else begin
            n_checks++; if (q[0] !== ev_t'{cyc: 93, key: 5'd19, pressed: 1'b1}) begin
                n_fail++; $display("FAIL b2b_ev0 got cyc %0d key %0d p %b want 93/19/1", q[0].cyc, q[0].key, q[0].pressed);
            end
            n_checks++; if (q[1] !== ev_t'{cyc: 94, key: 5'd20, pressed: 1'b1}) begin
                n_fail++; $display("FAIL b2b_ev1 got cyc %0d key %0d p %b want 94/20/1", q[1].cyc, q[1].key, q[1].pressed);
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset(32'h8100_0000, 1'b0);
        wait_until(103);
        n_checks++; if (ev_valid !== 1'b0 || keys !== 32'h0) begin n_fail++; $display("FAIL bp_pre valid %b keys %h want 0/0", ev_valid, keys); end
        for (int i = 104; i <= 123; i++) begin
            wait_until(i);
            n_checks++; if (ev_valid !== 1'b1 || ev_key !== 5'd24 || ev_pressed !== 1'b1 || col_en !== 4'b0111) begin
                n_fail++; $display("FAIL bp_stall cyc %0d got %b/%0d/%b col %b want 1/24/1 col 0111", i, ev_valid, ev_key, ev_pressed, col_en);
            end
        end
        ready = 1'b1;
        wait_until(131);
        n_checks++; if (col_en !== 4'b0111) begin n_fail++; $display("FAIL bp_next_col got %b want 0111", col_en); end
        wait_until(132);
        n_checks++; if (col_en !== 4'b1110) begin n_fail++; $display("FAIL bp_wrap_col got %b want 1110", col_en); end
        n_checks++; if (keys !== 32'h8100_0000) begin n_fail++; $display("FAIL bp_keys got %h want 81000000", keys); end
        n_checks++;
        if (q.size() != 2) begin n_fail++; $display("FAIL bp_count got %0d want 2", q.size()); end
        else begin
            n_checks++; if (q[0] !== ev_t'{cyc: 123, key: 5'd24, pressed: 1'b1}) begin
                n_fail++; $display("FAIL bp_ev0 got cyc %0d key %0d p %b want 123/24/1", q[0].cyc, q[0].key, q[0].pressed);
            end
            n_checks++; if (q[1] !== ev_t'{cyc: 130, key: 5'd31, pressed: 1'b1}) begin
                n_fail++; $display("FAIL bp_ev1 got cyc %0d key %0d p %b want 130/31/1", q[1].cyc, q[1].key, q[1].pressed);
            end
        end
    endtask

    task automatic test_reset_in_emit();
        apply_reset(32'h0100_0000, 1'b0);
        wait_until(110);
        n_checks++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL rie_pending got %b want 1", ev_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rie_valid got %b want 0", ev_valid); end
        n_checks++; if (keys !== 32'h0) begin n_fail++; $display("FAIL rie_keys got %h want 0", keys); end
        n_checks++; if (col_en !== 4'b1110) begin n_fail++; $display("FAIL rie_col got %b want 1110", col_en); end
        pressed = '0;
        ready   = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_until(60);
        n_checks++; if (q.size() != 0 || keys !== 32'h0) begin n_fail++; $display("FAIL rie_discard events %0d keys %h want 0/0", q.size(), keys); end
    endtask

    task automatic test_debounce_one();
        int exp_cyc[4];
        logic [3:0] exp_p;
        exp_cyc = '{6, 62, 118, 174};
        exp_p   = 4'b0101;
        apply_reset(32'h0000_0001, 1'b1);
        wait_until(30);  pressed = '0;
        wait_until(90);  pressed[0] = 1'b1;
        wait_until(140); pressed = '0;
        wait_until(180);
        n_checks++; if (keys1 !== 32'h0) begin n_fail++; $display("FAIL d1_keys got %h want 0", keys1); end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL d1_dc2_events got %0d want 0", q.size()); end
        n_checks++;
        if (q1.size() != 4) begin n_fail++; $display("FAIL d1_count got %0d want 4", q1.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (q1[i] !== ev_t'{cyc: exp_cyc[i], key: 5'd0, pressed: exp_p[i]}) begin
                    n_fail++; $display("FAIL d1_ev%0d got cyc %0d key %0d p %b want %0d/0/%b", i, q1[i].cyc, q1[i].key, q1[i].pressed, exp_cyc[i], exp_p[i]);
                end
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        pressed  = '0;
        ready    = 1'b1;
        ready1   = 1'b1;
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_idle_scan();
        test_press_release();
        test_glitch();
        test_back_to_back();
        test_backpressure();
        test_reset_in_emit();
        test_debounce_one();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
